// File: rtl/adder8_pipe_rr_sched.sv
// -----------------------------------------------------------------------------
// adder8_pipe_rr_sched
//
// Round-robin scheduler that shares one LAT-stage pipelined WIDTH-bit adder
// among NREQ requesters. At most one request is granted per cycle. The
// winner's operands are steered onto the adder inputs, and the winner's index
// travels down a tag shift register matched to the adder latency. When the sum
// emerges, it is registered together with the tag, so every result returns to
// the requester that issued it.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req        : per-requester request; held high until granted
//   req_a/b    : per-requester operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin    : per-requester carry-in
//   hold       : 1 = issue no new grants; in-flight operations still drain
//   gnt        : one-hot grant, combinational, in the same cycle as the request
//   add_a/b    : operands driven to the shared adder
//   add_cin    : carry-in driven to the shared adder
//   add_sum    : adder sum, valid LAT edges after the operands were sampled
//   add_cout   : adder carry-out, aligned with add_sum
//   rsp_valid  : registered one-cycle result strobe
//   rsp_id     : index of the requester that owns the result
//   rsp_sum    : registered result sum
//   rsp_cout   : registered result carry
//   busy       : high while any operation is in flight or rsp_valid is high
// -----------------------------------------------------------------------------
module adder8_pipe_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic                  hold,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  // Round-robin pointer: the index that has highest priority this cycle.
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;

  // Arbitration result.
  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW:0]     cand;

  // Tag pipeline, one stage per adder stage.
  logic [LAT-1:0]   vld_q;
  logic [IDW-1:0]   id_q [LAT];

  // Result registers.
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;

  // Search upward from ptr_q with wrap-around. The candidate index is formed
  // one bit wider than a tag so the wrap can be done with a single subtract,
  // which also works when NREQ is not a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
    // Drain mode: still compute a winner index, but issue nothing.
    if (hold) begin
      win_found = 1'b0;
    end
  end

  // One-hot grant and operand steering; the adder sees zeros when idle.
  always_comb begin
    gnt     = '0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_found && (win_idx == IDW'(k))) begin
        gnt[k]  = 1'b1;
        add_a   = req_a[k*WIDTH +: WIDTH];
        add_b   = req_b[k*WIDTH +: WIDTH];
        add_cin = req_cin[k];
      end
    end
  end

  // Priority moves just past the winner; frozen when nothing is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (win_found) begin
      ptr_d = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Tag shift register: stage 0 is loaded on the same edge that the adder
  // samples its operands, so stage LAT-1 lines up with add_sum/add_cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        id_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= win_found;
      id_q[0]  <= win_idx;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        id_q[s]  <= id_q[s-1];
      end
    end
  end

  // Capture the adder output with its owner's tag; payload holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
    end else begin
      rsp_valid_q <= vld_q[LAT-1];
      if (vld_q[LAT-1]) begin
        rsp_id_q   <= id_q[LAT-1];
        rsp_sum_q  <= add_sum;
        rsp_cout_q <= add_cout;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign busy      = (|vld_q) | rsp_valid_q;

endmodule
